// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: Wishbone classic master feeding a first-word fall-through
// prefetch queue, with branch redirect that flushes the queue and discards in-flight data.
module if_prefetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_i,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [DATA_WIDTH-1:0]         instr_o,
  output logic [ADDR_WIDTH-1:0]         pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  input  logic                          wb_ack_i,
  output logic [ADDR_WIDTH-1:0]         wb_adr_o,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  input  logic [DATA_WIDTH-1:0]         wb_dat_i,
  output logic [DATA_WIDTH/8-1:0]       wb_sel_o,
  output logic                          wb_we_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                state_q;
  logic                  cyc_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] redir_pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  push;
  logic                  pop;
  logic                  room_after;
  logic                  unused_redir_lsb;

  assign redir_pc         = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc_i[1:0];
  assign pc_next          = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
  assign pop              = instr_valid_o & instr_ready_i;
  assign push             = (state_q == StFetch) & cyc_q & wb_ack_i & ~redirect_i;
  // Room for another request once this cycle's push/pop settle; keeps a slot reserved.
  assign room_after       = (count_q + CntW'(1) - CntW'(pop)) < CntW'(FIFO_DEPTH);

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];
  assign fifo_count_o  = count_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = '0;
  assign wb_sel_o      = '1;
  assign wb_we_o       = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect_i) begin
            fetch_pc_q <= redir_pc;
          end else if (count_q < CntW'(FIFO_DEPTH)) begin
            cyc_q   <= 1'b1;
            adr_q   <= fetch_pc_q;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (redirect_i) begin
            fetch_pc_q <= redir_pc;
            // Acked word is dropped; reissue straight to the target, else wait out the ack.
            if (wb_ack_i) adr_q <= redir_pc;
            else          state_q <= StDrain;
          end else if (wb_ack_i) begin
            fetch_pc_q <= pc_next;
            if (room_after) begin
              adr_q <= pc_next;
            end else begin
              cyc_q   <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StDrain: begin
          if (redirect_i) fetch_pc_q <= redir_pc;
          if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= wb_dat_i;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: random Wishbone slave, consumer, redirects and resets, with a
// scoreboard of expected sequential PCs that a monitor pops on every accepted handshake.
module tb_if_prefetch_unit;

  localparam logic [31:0] ResetPc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  fifo_count_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;

  if_prefetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .fifo_count_o  (fifo_count_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_ack_i      (wb_ack_i),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_o      (wb_sel_o),
    .wb_we_o       (wb_we_o)
  );

  always #5 clk = ~clk;

  // Stimulus knobs, written by the main sequence and read by the driver.
  int unsigned max_wait   = 0;
  int unsigned ready_pct  = 0;
  int unsigned redir_pct  = 0;
  int unsigned reset_pml  = 0;
  int unsigned spur_pct   = 0;
  logic        rst_req    = 1'b1;
  int unsigned redir_cnt  = 0;
  int unsigned redir_seen = 0;
  logic [31:0] redir_addr = '0;
  int unsigned wait_cnt   = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  logic seen_wrap = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_adr  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    reset         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    wb_ack_i      = 1'b0;
    wb_dat_i      = '0;
  end

  // Driver: inputs change 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    reset = rst_req || ($urandom_range(999) < reset_pml);
    if (redir_cnt != redir_seen) begin
      redir_seen    = redir_cnt;
      redirect_i    = 1'b1;
      redirect_pc_i = redir_addr;
    end else begin
      redirect_i    = ($urandom_range(99) < redir_pct);
      redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
    end
    instr_ready_i = ($urandom_range(99) < ready_pct);
    if (wb_cyc_o) begin
      if (wait_cnt == 0) begin
        wb_ack_i = 1'b1;
        wb_dat_i = mem_word(wb_adr_o);
        wait_cnt = $urandom_range(max_wait);
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        wait_cnt--;
      end
    end else begin
      wb_ack_i = ($urandom_range(99) < spur_pct);
      wb_dat_i = $urandom;
    end
  end

  // Monitor: protocol checks plus scoreboard of the expected in-order PC stream.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      next_pc   = ResetPc;
      prev_pend = 1'b0;
    end else begin
      chk("cyc_eq_stb", 32'(wb_stb_o), 32'(wb_cyc_o));
      chk("valid_vs_count", 32'(instr_valid_o), 32'(fifo_count_o != 3'd0));
      chk("count_le_depth", 32'(fifo_count_o <= 3'd4), 32'd1);
      chk("adr_aligned", 32'(wb_adr_o[1:0]), 32'd0);
      if (prev_pend) begin
        chk("cyc_hold", 32'(wb_cyc_o), 32'd1);
        chk("adr_hold", wb_adr_o, prev_adr);
      end
      if (instr_valid_o && instr_ready_i) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got pc %h with nothing expected", pc_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("pc", pc_o, e);
          chk("instr", instr_o, mem_word(e));
          if (e == 32'h0 && pc_o == 32'h0) seen_wrap = 1'b1;
        end
      end
      if (redirect_i) begin
        exp_q.delete();
        next_pc = {redirect_pc_i[31:2], 2'b00};
      end
      prev_pend = wb_cyc_o && !wb_ack_i;
      prev_adr  = wb_adr_o;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);

    // Zero-wait slave, consumer stalled: queue fills, then one pop frees a slot.
    rst_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("first_cyc", 32'(wb_cyc_o), 32'd1);
    chk("first_adr", wb_adr_o, 32'h8000_0000);
    repeat (8) @(negedge clk);
    chk("full_count", 32'(fifo_count_o), 32'd4);
    chk("full_cyc", 32'(wb_cyc_o), 32'd0);
    chk("full_head_pc", pc_o, 32'h8000_0000);
    ready_pct = 100;
    @(negedge clk);
    ready_pct = 0;
    @(negedge clk);
    chk("after_pop_count", 32'(fifo_count_o), 32'd3);
    chk("after_pop_cyc", 32'(wb_cyc_o), 32'd0);
    @(negedge clk);
    chk("refill_cyc", 32'(wb_cyc_o), 32'd1);
    chk("refill_adr", wb_adr_o, 32'h8000_0010);

    // Unaligned redirect near the top of the address space, exercising wrap to zero.
    max_wait   = 1;
    ready_pct  = 100;
    redir_addr = 32'hFFFF_FFFA;
    redir_cnt++;
    repeat (20) @(negedge clk);
    chk("wrap_seen", 32'(seen_wrap), 32'd1);

    // Redirect while a slow fetch is outstanding: its data must never surface.
    max_wait  = 3;
    ready_pct = 0;
    for (int i = 0; i < 20 && !(wb_cyc_o && !wb_ack_i); i++) @(negedge clk);
    redir_addr = 32'h8000_1002;
    redir_cnt++;
    @(negedge clk);
    ready_pct = 100;
    repeat (30) @(negedge clk);

    // Randomised phases with redirects, resets and stray acks.
    for (int ph = 0; ph < 15; ph++) begin
      max_wait  = $urandom_range(3);
      ready_pct = $urandom_range(100, 30);
      redir_pct = $urandom_range(10, 2);
      reset_pml = $urandom_range(15);
      spur_pct  = $urandom_range(20);
      repeat (200) @(negedge clk);
    end
    chk("progress", 32'(n_hs > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the five-stage pipeline. Replaces the single-word fetch path with a Wishbone classic master and a FIFO prefetch queue of configurable depth.
- Supports branch redirect with queue flush and safe discard of in-flight fetches.
- Feeds the IF/ID pipeline register through a valid/ready handshake, so the pipeline stalls by deasserting ready.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, instruction/data width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, >=2.
- PC_STEP, 4, increment between sequential fetches.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect_i  in  1  branch/jump taken; flush queue and restart.
- redirect_pc_i  in  ADDR_WIDTH  new fetch address; low 2 bits forced to 0.
- instr_valid_o  out  1  head entry valid.
- instr_ready_i  in  1  consumer accepts head this cycle.
- instr_o  out  DATA_WIDTH  head instruction.
- pc_o  out  ADDR_WIDTH  PC of head instruction.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_adr_o  out  ADDR_WIDTH  fetch address.
- wb_dat_o  out  DATA_WIDTH  constant 0.
- wb_dat_i  in  DATA_WIDTH  fetched word.
- wb_sel_o  out  DATA_WIDTH/8  constant all ones.
- wb_we_o  out  1  constant 0.

Behaviour:
- Reset values:
  - cyc, stb, we, valid = 0; adr = 0; dat_o = 0; sel = all ones; count = 0.
  - Internal fetch_pc = RESET_PC; state = IDLE.
- At most one outstanding Wishbone request; cyc and stb are always equal.
- FSM states are IDLE, FETCH and DRAIN.
- IDLE:
  - If count < FIFO_DEPTH and no redirect: next cycle assert cyc/stb, adr = fetch_pc, enter FETCH.
  - First request therefore appears at the cycle after reset deasserts.
- FETCH: hold adr/cyc/stb stable until ack. On ack without redirect:
  - Push {fetch_pc, wb_dat_i}; fetch_pc += PC_STEP.
  - If count + 1 - pop < FIFO_DEPTH, stay in FETCH and present the new adr next cycle (back-to-back fetch).
  - Otherwise drop cyc/stb and go to IDLE.
- Redirect (any state):
  - Queue is emptied; count = 0 next cycle.
  - fetch_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}.
- Redirect in FETCH with no ack that cycle: go to DRAIN, keeping cyc/stb high until ack.
- Redirect with ack in the same cycle: wb_dat_i is discarded; the next cycle issues to the redirect address (FETCH).
- DRAIN:
  - Ack is consumed and its data discarded; then drop cyc/stb and go to IDLE.
  - A further redirect while in DRAIN updates fetch_pc only.
- Queue behaviour:
  - First-word fall-through: instr_valid_o = (count != 0); instr_o/pc_o show the head combinationally from storage.
  - Pop occurs when instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Full: no new request is issued; the single outstanding request always has a reserved slot, so overflow is impossible.
- Empty: valid = 0; ready is ignored.
- Redirect and pop in the same cycle: the pop is a completed handshake (consumer owns that word), and the flush still empties the queue.
- Reset mid-transaction: cyc/stb drop the next cycle. Any later ack seen in IDLE is ignored.
- An ack with cyc = 0 is ignored.
- fetch_pc wraps at 2^ADDR_WIDTH.

Test Plan:
1. Reset release, slave ack after 1 wait cycle, ready=1: wb_adr_o = 8000_0000, 8000_0004, 8000_0008. Outputs pc_o/instr_o match in order, one per 2 cycles.
2. Zero-wait slave (ack same cycle as stb), ready=0, FIFO_DEPTH=4: exactly 4 fetches, then cyc=0 with count=4. Raising ready for 1 cycle pops 8000_0000 and issues 8000_0010.
3. Redirect to 8000_1002 while a fetch is waiting (ack delayed 3 cycles): cyc held until ack; that data is never output. Next adr = 8000_1000; the first output is pc_o = 8000_1000.
4. Redirect coincident with ack and with ready=1, count=2: the head pops and count = 0 next cycle. The ack data is dropped; the next fetch goes to the redirect address.
5. Assert reset while cyc=1, then ack 2 cycles later: cyc=0 after reset. The ack is ignored, count stays 0, and the first post-reset fetch is 8000_0000.
6. fetch_pc at FFFF_FFFC: the next adr is 0000_0000.
